// File: rtl/mem_stage_hs_if.sv
// Data-memory bus between the MEM stage (master) and a variable-latency memory (slave).
// Level request held until a one-cycle done pulse returns.
interface mem_stage_hs_if #(
    parameter int DATA_W = 16
) ();
    logic              mem_req;
    logic              mem_wr;
    logic [DATA_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_dump;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_done;

    modport master (
        output mem_req,
        output mem_wr,
        output mem_addr,
        output mem_wdata,
        output mem_dump,
        input  mem_rdata,
        input  mem_done
    );

    modport slave (
        input  mem_req,
        input  mem_wr,
        input  mem_addr,
        input  mem_wdata,
        input  mem_dump,
        output mem_rdata,
        output mem_done
    );
endinterface

// File: rtl/mem_stage_hs.sv
// Pipeline MEM stage owning the MEM/WB register, with req/done handshake, squash and timeout abort.
// Optional misaligned-access trap enabled by defining MISALIGN_CHK_EN.
module mem_stage_hs #(
    parameter int DATA_W  = 16,
    parameter int REG_W   = 3,
    parameter int TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              valid_exmem,
    input  logic [DATA_W-1:0] alu_o_exmem,
    input  logic [DATA_W-1:0] rd2_exmem,
    input  logic              take_branch,
    input  logic              mem_read_exmem,
    input  logic              mem_write_exmem,
    input  logic              reg_write_exmem,
    input  logic              mem_to_reg_exmem,
    input  logic              dump_exmem,
    input  logic              halt_exmem,
    input  logic [REG_W-1:0]  wr_r_exmem,
    mem_stage_hs_if.master    memBus,
    output logic              stall_mem,
    output logic              valid_memwb,
    output logic [DATA_W-1:0] rdd_memwb,
    output logic [DATA_W-1:0] alu_o_memwb,
    output logic              mem_to_reg_memwb,
    output logic              reg_write_memwb,
    output logic [REG_W-1:0]  wr_r_memwb,
    output logic              halt_memwb,
    output logic              err_memwb
);
    // state | meaning
    // IDLE  | no access outstanding; the EX/MEM instruction is evaluated this cycle
    // WAIT  | access issued; mem_req held until done or the timeout abort
    typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} stateT;

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic ALIGN_APPLIES = (DATA_W > 8);

    stateT            state;
    stateT            stateNxt;
    logic [CNT_W-1:0] waitCnt;
    logic             live;
    logic             acc;
    logic             misAlign;
    logic             reqOut;
    logic             stallOut;
    logic             doneAcc;
    logic             abortAcc;
    logic             errNow;
    logic             liveEff;

    assign live = valid_exmem & ~take_branch;
    assign acc  = live & (mem_read_exmem | mem_write_exmem);

`ifdef MISALIGN_CHK_EN
    assign misAlign = acc & ALIGN_APPLIES & alu_o_exmem[0];
`else
    assign misAlign = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= stateNxt;
        end
    end

    // mem_done is only consulted while a request is actually on the bus, so a
    // stray done pulse and a done in the abort cycle are both ignored.
    always_comb begin
        stateNxt = state;
        reqOut   = 1'b0;
        stallOut = 1'b0;
        doneAcc  = 1'b0;
        abortAcc = 1'b0;
        case (state)
            IDLE: begin
                if (acc && !misAlign) begin
                    reqOut = 1'b1;
                    if (memBus.mem_done) begin
                        doneAcc = 1'b1;
                    end else begin
                        stallOut = 1'b1;
                        stateNxt = WAIT;
                    end
                end
            end
            WAIT: begin
                if (waitCnt == CNT_LAST) begin
                    abortAcc = 1'b1;
                    stateNxt = IDLE;
                end else begin
                    reqOut = 1'b1;
                    if (memBus.mem_done) begin
                        doneAcc  = 1'b1;
                        stateNxt = IDLE;
                    end else begin
                        stallOut = 1'b1;
                    end
                end
            end
            default: begin
                stateNxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            waitCnt <= '0;
        end else if (state == WAIT) begin
            waitCnt <= waitCnt + CNT_W'(1);
        end else begin
            waitCnt <= '0;
        end
    end

    // Combinational outputs are gated by rst_n so an access abandoned by reset
    // drops off the bus immediately, even with EX/MEM still presenting it.
    assign memBus.mem_req   = reqOut & rst_n;
    assign memBus.mem_wr    = memBus.mem_req & mem_write_exmem;
    assign memBus.mem_addr  = memBus.mem_req ? alu_o_exmem : '0;
    assign memBus.mem_wdata = memBus.mem_req ? rd2_exmem : '0;
    assign stall_mem        = stallOut & rst_n;
    assign memBus.mem_dump  = dump_exmem & live & (state == IDLE) & ~stallOut & rst_n;

    // Once in WAIT the instruction is committed; take_branch no longer applies.
    assign liveEff = live | (state == WAIT);
    assign errNow  = abortAcc | misAlign;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_memwb      <= 1'b0;
            rdd_memwb        <= '0;
            alu_o_memwb      <= '0;
            mem_to_reg_memwb <= 1'b0;
            reg_write_memwb  <= 1'b0;
            wr_r_memwb       <= '0;
            halt_memwb       <= 1'b0;
            err_memwb        <= 1'b0;
        end else if (stallOut) begin
            valid_memwb      <= 1'b0;
            rdd_memwb        <= '0;
            alu_o_memwb      <= '0;
            mem_to_reg_memwb <= 1'b0;
            reg_write_memwb  <= 1'b0;
            wr_r_memwb       <= '0;
            halt_memwb       <= 1'b0;
            err_memwb        <= 1'b0;
        end else begin
            valid_memwb      <= liveEff;
            rdd_memwb        <= (doneAcc && mem_read_exmem && !mem_write_exmem) ? memBus.mem_rdata : '0;
            alu_o_memwb      <= alu_o_exmem;
            mem_to_reg_memwb <= mem_to_reg_exmem;
            reg_write_memwb  <= reg_write_exmem & liveEff & ~errNow;
            wr_r_memwb       <= wr_r_exmem;
            halt_memwb       <= halt_exmem & liveEff;
            err_memwb        <= errNow;
        end
    end
endmodule
